bank_arbiter: RTL
=================

Name: bank_arbiter

Overview:
- Round-robin arbiter that shares one single-port memory bank between NUM_REQ requesters (core load/store units).
- Sits directly in front of a bank and drives its addr, data_in, read_enable and write_enable pins.
- The bank has 1-cycle registered read latency; the arbiter tags returning read data with the requester ID.
- One access per cycle; write-or-read per grant.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of requester ID; must equal clog2(NUM_REQ).
- ADDR_W, 8, bank address width (256 words).
- DATA_W, 8, word width (REG_SIZE).
- MAX_LOCK, 4, maximum consecutive grants under lock (optional feature only).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset; 0 = reset asserted.
- req  in  NUM_REQ  per-requester access request.
- req_we  in  NUM_REQ  1 = write, 0 = read; qualified by req.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_W  packed write data, same packing.
- req_lock  in  NUM_REQ  hold-grant request (used only with the optional feature).
- gnt  out  NUM_REQ  one-hot grant, combinational, same cycle as req.
- bank_addr  out  ADDR_W  to bank addr.
- bank_data_in  out  DATA_W  to bank data_in.
- bank_read_enable  out  1  to bank read_enable.
- bank_write_enable  out  1  to bank write_enable.
- bank_data_out  in  DATA_W  from bank data_out.
- rvalid  out  1  read data valid.
- rid  out  ID_W  requester ID for rdata.
- rdata  out  DATA_W  read data, equal to bank_data_out.

Behaviour:
- State: rr_ptr (ID_W bits), rd_pend (1 bit), rd_id (ID_W bits). Optional lock state is described below.
- Reset (reset=0, asynchronous): rr_ptr=0, rd_pend=0, rd_id=0. Outputs during and after reset: rvalid=0, rid=0, gnt=0. Bank enables are 0 while reset=0.
- Grant selection is combinational:
  - Search req starting at index rr_ptr, ascending, wrapping at NUM_REQ-1 -> 0.
  - The first set bit wins; gnt is one-hot, or all-zero if req==0.
- Bank drive:
  - bank_addr and bank_data_in come from the winner's slice.
  - bank_write_enable = winner valid & req_we[w].
  - bank_read_enable = winner valid & ~req_we[w].
  - With no winner: both enables are 0, and addr/data are 0.
- Pointer update at posedge: if a grant occurred to index w, rr_ptr <= (w==NUM_REQ-1) ? 0 : w+1. Otherwise rr_ptr holds.
- Read return:
  - On a granted read, rd_pend <= 1 and rd_id <= w; otherwise rd_pend <= 0.
  - rvalid = rd_pend and rid = rd_id, so they are valid in cycle N+1 for a read granted in cycle N, aligned with the bank's registered data_out.
  - rdata = bank_data_out when rvalid=1, else 0.
- Handshake: a requester holds req, we, addr and wdata stable until it sees gnt[i]=1 in the same cycle. The transfer completes at that clock edge. A requester may re-request back-to-back.
- Fairness: with all NUM_REQ requesting continuously, each is granted exactly once every NUM_REQ cycles.
- A write and a read to the same address in consecutive cycles: the read returns the new data (bank write lands before the next read edge).
- Reset asserted mid-read: a pending rvalid is dropped and never reissued.
- Unused ID values (NUM_REQ not a power of 2) are never produced.

Optional Feature:
- Macro: BANK_ARB_LOCK_EN.
- With the macro defined:
  - Add lock_cnt (clog2(MAX_LOCK+1) bits, reset 0) and lock_own (ID_W bits, reset 0).
  - If the current winner w has req_lock[w]=1 and lock_cnt < MAX_LOCK-1: lock_own <= w, lock_cnt <= lock_cnt+1, and rr_ptr is not advanced. The next grant goes to w if req[w] is still set.
  - When req[w] drops, req_lock[w] drops, or lock_cnt reaches MAX_LOCK-1: lock_cnt <= 0 and rr_ptr advances normally. A single requester therefore gets at most MAX_LOCK consecutive grants.
- Without the macro: req_lock is ignored and no lock state exists.

Test Plan:
- Reset release, req=0 -> gnt=0000, both bank enables 0, rvalid=0, rr_ptr=0.
- req[2]=1 write addr 0x10 data 0xA5, next cycle req[1] read addr 0x10 -> cycle 0 gnt=0100 with bank_write_enable=1. Cycle 1 gnt=0010 with bank_read_enable=1. Cycle 2 rvalid=1, rid=1, rdata=0xA5.
- req=1111 held 8 cycles, all reads -> gnt sequence 0001,0010,0100,1000,0001,...; rvalid every cycle from cycle 1 with rid 0,1,2,3,0,...
- req=1001 with rr_ptr=1 -> gnt=1000 first, then 0001, then 1000 (wrap-around).
- Read granted, then reset pulled low for 1 cycle before the next edge -> rvalid stays 0 and rr_ptr=0 after release.
- BANK_ARB_LOCK_EN defined, MAX_LOCK=4, req=0011, req_lock=0001 -> gnt 0001 for 4 cycles, then 0010, then 0001 again.

Source files
------------

// File: rtl/bank_arbiter_if.sv
// bank_arbiter_if: request/grant bus, bank pins and tagged read return of
// the bank arbiter bundled into one interface.
//   slave  : arbiter view (takes requests and bank_data_out, drives gnt,
//            the bank pins and the read return)
//   master : requester/bank view (the reverse directions)
interface bank_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2,
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 8
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        req_we;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        req_lock;
    logic [NUM_REQ-1:0]        gnt;
    logic [ADDR_W-1:0]         bank_addr;
    logic [DATA_W-1:0]         bank_data_in;
    logic                      bank_read_enable;
    logic                      bank_write_enable;
    logic [DATA_W-1:0]         bank_data_out;
    logic                      rvalid;
    logic [ID_W-1:0]           rid;
    logic [DATA_W-1:0]         rdata;

    modport slave (
        input  req, req_we, req_addr, req_wdata, req_lock, bank_data_out,
        output gnt, bank_addr, bank_data_in, bank_read_enable,
               bank_write_enable, rvalid, rid, rdata
    );

    modport master (
        output req, req_we, req_addr, req_wdata, req_lock, bank_data_out,
        input  gnt, bank_addr, bank_data_in, bank_read_enable,
               bank_write_enable, rvalid, rid, rdata
    );
endinterface

// File: rtl/bank_arbiter.sv
// bank_arbiter: round-robin arbiter sharing one single-port memory bank
// (1-cycle registered read latency) between NUM_REQ requesters.
//   clk   : clock
//   reset : asynchronous active-low reset
//   bus   : bank_arbiter_if.slave -- req/req_we/req_addr/req_wdata/req_lock
//           in, combinational one-hot gnt out, bank pins out, bank_data_out
//           in, read return rvalid/rid/rdata out (rvalid one cycle after the
//           read grant, aligned with the bank's registered data_out).
// Optional feature: define BANK_ARB_LOCK_EN to let a requester holding
// req_lock keep the grant for up to MAX_LOCK consecutive cycles.
module bank_arbiter #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned ID_W     = 2,
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned DATA_W   = 8
`ifdef BANK_ARB_LOCK_EN
    ,
    parameter int unsigned MAX_LOCK = 4
`endif
) (
    input  logic          clk,
    input  logic          reset,
    bank_arbiter_if.slave bus
);

    logic [ID_W-1:0]   rr_ptr;
    logic              rd_pend;
    logic [ID_W-1:0]   rd_id;
    logic              win_vld;
    logic [ID_W-1:0]   win_id;
    logic [ID_W-1:0]   ptr_nxt;
    logic              hold;

    logic [ADDR_W-1:0] addr_a [NUM_REQ];
    logic [DATA_W-1:0] wdata_a [NUM_REQ];

    // Unpack the per-requester address/data slices
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_a[g]  = bus.req_addr[g*ADDR_W +: ADDR_W];
        assign wdata_a[g] = bus.req_wdata[g*DATA_W +: DATA_W];
    end

    // Winner search: first set req at or after rr_ptr, wrapping; none in reset
    always_comb begin
        int unsigned     idx;
        logic [ID_W-1:0] cand;
        win_vld = 1'b0;
        win_id  = '0;
        idx     = 0;
        cand    = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = 32'(rr_ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            cand = ID_W'(idx);
            if (!win_vld && bus.req[cand]) begin
                win_vld = 1'b1;
                win_id  = cand;
            end
        end
        if (!reset) begin
            win_vld = 1'b0;
        end
    end

    // Grant and bank drive from the winner's slice; all zero when idle
    always_comb begin
        bus.gnt               = '0;
        bus.bank_addr         = '0;
        bus.bank_data_in      = '0;
        bus.bank_write_enable = 1'b0;
        bus.bank_read_enable  = 1'b0;
        if (win_vld) begin
            bus.gnt[win_id]       = 1'b1;
            bus.bank_addr         = addr_a[win_id];
            bus.bank_data_in      = wdata_a[win_id];
            bus.bank_write_enable = bus.req_we[win_id];
            bus.bank_read_enable  = ~bus.req_we[win_id];
        end
    end

    assign ptr_nxt = (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + ID_W'(1);

`ifdef BANK_ARB_LOCK_EN
    localparam int unsigned LOCK_W = $clog2(MAX_LOCK + 1);

    logic [LOCK_W-1:0] lock_cnt;
    logic [ID_W-1:0]   lock_own;
    logic [LOCK_W-1:0] cur_cnt;

    // A new winner starts its lock run from zero
    always_comb begin
        cur_cnt = (win_id == lock_own) ? lock_cnt : '0;
        hold    = win_vld && bus.req_lock[win_id] &&
                  (cur_cnt < LOCK_W'(MAX_LOCK - 1));
    end

    // Lock run length and owner
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lock_cnt <= '0;
            lock_own <= '0;
        end else if (hold) begin
            lock_cnt <= cur_cnt + LOCK_W'(1);
            lock_own <= win_id;
        end else begin
            lock_cnt <= '0;
        end
    end
`else
    logic unused_lock;
    assign unused_lock = ^bus.req_lock;
    assign hold        = 1'b0;
`endif

    // Round-robin pointer and read-return tracking
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr  <= '0;
            rd_pend <= 1'b0;
            rd_id   <= '0;
        end else begin
            if (win_vld) begin
                rr_ptr <= hold ? win_id : ptr_nxt;
            end
            rd_pend <= win_vld & ~bus.req_we[win_id];
            if (win_vld && !bus.req_we[win_id]) begin
                rd_id <= win_id;
            end
        end
    end

    assign bus.rvalid = rd_pend;
    assign bus.rid    = rd_id;
    assign bus.rdata  = rd_pend ? bus.bank_data_out : '0;

endmodule
